// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- iterative multiply/divide sequencer with HI/LO registers.
//
// Runs MULT/MULTU/DIV/DIVU as a 32-step loop on one shared adder.
// Multiply is shift-add, LSB first. Divide is restoring, MSB first.
// After the loop, one fix-up cycle applies the result signs.
// The block also services MTHI/MTLO writes while idle.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   start, op    request qualifier; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B         operands (rs, rt); A is also the MTHI/MTLO data
//   mthi, mtlo   write A into HI / LO (only honoured while idle)
//   busy         operation in flight
//   done         one-cycle pulse: hi/lo hold a new result
//   div_zero     divide-by-zero pulse, coincident with done
//   hi, lo       architectural HI/LO registers
//
// Build option MULDIV_DIVZERO_FLAG_EN:
//   When defined, a divide by zero skips the loop, leaves HI/LO untouched
//   and pulses div_zero.
//   When undefined, the divide runs the full loop and yields LO=all-ones
//   and HI=A, and div_zero is tied low.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc;
  logic [31:0] opa;       // multiplicand / dividend magnitude (dividend shifts left)
  logic [31:0] opb;       // multiplier (shifts right) / divisor magnitude
  logic [4:0]  cnt;
  logic        is_div, qsign, rsign;

  logic        signed_op, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag;
  logic        qsign_in, rsign_in;

  logic [32:0] add_a, add_b;
  logic        add_cin;
  logic [33:0] add_sum;
  logic        no_borrow;
  logic [31:0] new_rem;

  logic [63:0] prod_neg;
  logic [31:0] fix_hi, fix_lo;
  logic        fix_wr;

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        dz;
`endif

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & A[31];
  assign b_neg     = signed_op & B[31];
  assign b_zero    = (B == '0);
  assign busy      = (state != S_IDLE);

  // Operand magnitudes and result signs captured on an accepted start.
  // The magnitude of 0x80000000 is 0x80000000 read as unsigned, so the
  // 32-bit magnitudes and the 64-bit accumulator produce the exact product.
  always_comb begin
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    qsign_in = a_neg ^ b_neg;
    rsign_in = a_neg;
`ifndef MULDIV_DIVZERO_FLAG_EN
    // Divide by zero keeps raw A, so the loop leaves HI=A unsigned-style.
    if (op[1] && b_zero) begin
      a_mag    = A;
      qsign_in = 1'b0;
      rsign_in = 1'b0;
    end
`endif
  end

  // The single shared adder.
  // Multiply: acc_hi + (opb[0] ? opa : 0).
  // Divide: {rem, next dividend bit} - divisor, where bit 33 is the
  // no-borrow flag.
  always_comb begin
    if (is_div) begin
      add_a   = {acc[63:32], opa[31]};
      add_b   = ~{1'b0, opb};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc[63:32]};
      add_b   = opb[0] ? {1'b0, opa} : '0;
      add_cin = 1'b0;
    end
    add_sum   = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};
    no_borrow = add_sum[33];
    new_rem   = no_borrow ? add_sum[31:0] : add_a[31:0];
  end

  // Sign fix-up applied during FIX.
  always_comb begin
    prod_neg = 64'd0 - acc;
    if (is_div) begin
      fix_hi = rsign ? (32'd0 - acc[63:32]) : acc[63:32];
      fix_lo = qsign ? (32'd0 - acc[31:0])  : acc[31:0];
    end else begin
      fix_hi = qsign ? prod_neg[63:32] : acc[63:32];
      fix_lo = qsign ? prod_neg[31:0]  : acc[31:0];
    end
`ifdef MULDIV_DIVZERO_FLAG_EN
    fix_wr = ~dz;
`else
    fix_wr = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIVZERO_FLAG_EN
          state_nxt = (op[1] && b_zero) ? S_FIX : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (mthi) hi <= A;
          if (mtlo) lo <= A;
          if (start) begin
            opa    <= a_mag;
            opb    <= b_mag;
            is_div <= op[1];
            qsign  <= qsign_in;
            rsign  <= rsign_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc <= {new_rem, acc[30:0], no_borrow};
            opa <= {opa[30:0], 1'b0};
          end else begin
            acc <= {add_sum[32:0], acc[31:1]};
            opb <= {1'b0, opb[31:1]};
          end
        end
        S_FIX: begin
          if (fix_wr) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dz       <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (state == S_IDLE && start) dz <= op[1] & b_zero;
      div_zero <= (state == S_FIX) & dz;
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
